// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART definitions for the receive deframer and the matching transmitter
//
// Purpose: FSM state encoding, data-bit count and the bit-period derivation
// used by both UART directions.
// Ports:   none (package)

package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      WAIT_IDLE
   } rx_state_t;

   localparam int DATA_BITS = 8;

   // Whole clock cycles per serial bit; the fractional remainder is dropped.
   function automatic int clks_per_bit(input int clk_hz, input int baud);
      return clk_hz / baud;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - generic two-flop synchronizer with a parameterised reset value
//
// Purpose: brings an asynchronous single-bit input into the clk domain.
// Ports:
//   clk    input   system clock
//   reset  input   synchronous, active-high reset; both flops load RESET_VAL
//   d      input   asynchronous input
//   q      output  synchronized output (second flop)

module sync_2ff #(
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk) begin
      if (reset) begin
         meta <= RESET_VAL;
         q    <= RESET_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/uart_rx_deframer.sv
// rtl/uart_rx_deframer.sv - 8N1 UART receiver with one-deep valid/ready holding register
//
// Purpose: recovers bytes from the serial line by mid-bit sampling and reports
// framing errors, break conditions and overruns as one-cycle pulses.
// Ports:
//   clk_50         input      system clock, rising edge
//   reset          input      synchronous, active-high reset
//   rxd            input      asynchronous serial input, idle high
//   out_data       output [8] received byte, LSB received first
//   out_valid      output     out_data holds an unconsumed byte
//   out_ready      input      consumer accepts out_data when out_valid & out_ready
//   framing_error  output     pulse: stop bit low with nonzero data
//   break_detect   output     pulse: all-zero data and stop bit low
//   overrun        output     pulse: byte completed while holding register full and not consumed
//   busy           output     FSM not in IDLE

module uart_rx_deframer
   import uart_pkg::*;
#(
   parameter int CLK_HZ       = 50000000,
   parameter int BAUD         = 115200,
   parameter int CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD)
) (
   input  logic                 clk_50,
   input  logic                 reset,
   input  logic                 rxd,
   output logic [DATA_BITS-1:0] out_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 framing_error,
   output logic                 break_detect,
   output logic                 overrun,
   output logic                 busy
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam int IDX_W = $clog2(DATA_BITS);
   localparam int HALF  = CLKS_PER_BIT / 2;

   localparam logic [CNT_W-1:0] CNT_HALF_LAST = CNT_W'(HALF - 1);
   localparam logic [CNT_W-1:0] CNT_BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [IDX_W-1:0] IDX_LAST      = IDX_W'(DATA_BITS - 1);

   logic rx_s;

   rx_state_t            state, state_nxt;
   logic [CNT_W-1:0]     cnt, cnt_nxt;
   logic [IDX_W-1:0]     bit_idx, bit_idx_nxt;
   logic [DATA_BITS-1:0] shreg, shreg_nxt;
   logic [DATA_BITS-1:0] out_data_nxt;
   logic                 out_valid_nxt;
   logic                 deliver;
   logic                 fe_nxt, brk_nxt, ovr_nxt;

   // Synchronizer resets to the idle line level so reset release cannot look like a start bit.
   sync_2ff #(
      .RESET_VAL(1'b1)
   ) u_sync (
      .clk  (clk_50),
      .reset(reset),
      .d    (rxd),
      .q    (rx_s)
   );

   always_ff @(posedge clk_50) begin
      if (reset) begin
         state         <= IDLE;
         cnt           <= '0;
         bit_idx       <= '0;
         shreg         <= '0;
         out_data      <= '0;
         out_valid     <= 1'b0;
         framing_error <= 1'b0;
         break_detect  <= 1'b0;
         overrun       <= 1'b0;
      end else begin
         state         <= state_nxt;
         cnt           <= cnt_nxt;
         bit_idx       <= bit_idx_nxt;
         shreg         <= shreg_nxt;
         out_data      <= out_data_nxt;
         out_valid     <= out_valid_nxt;
         framing_error <= fe_nxt;
         break_detect  <= brk_nxt;
         overrun       <= ovr_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      bit_idx_nxt = bit_idx;
      shreg_nxt   = shreg;
      deliver     = 1'b0;
      fe_nxt      = 1'b0;
      brk_nxt     = 1'b0;

      case (state)
         IDLE: begin
            if (!rx_s) begin
               cnt_nxt   = '0;
               state_nxt = START;
            end
         end
         START: begin
            if (cnt == CNT_HALF_LAST) begin
               cnt_nxt = '0;
               if (!rx_s) begin
                  bit_idx_nxt = '0;
                  state_nxt   = DATA;
               end else begin
                  // Line went back high before mid start bit: a glitch, not a frame.
                  state_nxt = IDLE;
               end
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         DATA: begin
            if (cnt == CNT_BIT_LAST) begin
               cnt_nxt     = '0;
               shreg_nxt   = {rx_s, shreg[DATA_BITS-1:1]};
               bit_idx_nxt = bit_idx + IDX_W'(1);
               if (bit_idx == IDX_LAST) begin
                  state_nxt = STOP;
               end
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         STOP: begin
            if (cnt == CNT_BIT_LAST) begin
               cnt_nxt = '0;
               if (rx_s) begin
                  deliver   = 1'b1;
                  state_nxt = IDLE;
               end else begin
                  if (shreg != '0) begin
                     fe_nxt = 1'b1;
                  end else begin
                     brk_nxt = 1'b1;
                  end
                  state_nxt = WAIT_IDLE;
               end
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         WAIT_IDLE: begin
            // Hold here until the line recovers so a stuck-low line cannot retrigger.
            if (rx_s) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Holding register: a consume in the same cycle as a delivery frees the slot for the new byte.
   always_comb begin
      out_data_nxt  = out_data;
      out_valid_nxt = out_valid;
      ovr_nxt       = 1'b0;

      if (deliver) begin
         if (!out_valid || out_ready) begin
            out_data_nxt  = shreg;
            out_valid_nxt = 1'b1;
         end else begin
            ovr_nxt = 1'b1;
         end
      end else if (out_valid && out_ready) begin
         out_valid_nxt = 1'b0;
      end
   end

   assign busy = (state != IDLE);

endmodule
